// File: rtl/npc_mc_ctrl_if.sv
// Bus bundle between the npc multi-cycle sequencer and its datapath/memories.
// master = sequencer side, slave = datapath + instruction/data memory side.
interface npc_mc_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [31:0]       pc;
  logic [31:0]       next_pc;
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic              ifu_rsp_valid;
  logic [31:0]       ifu_rsp_inst;
  logic [31:0]       inst;
  logic              is_mem;
  logic              has_rd;
  logic              is_ebreak;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_rsp_valid;
  logic              rf_wen;
  logic              halted;
  logic              error;
  logic [2:0]        state;
  logic [PERF_W-1:0] perf_cycles;
  logic [PERF_W-1:0] perf_insts;

  modport master (
    output pc, inst, ifu_req_valid, lsu_req_valid, rf_wen, halted, error, state,
           perf_cycles, perf_insts,
    input  next_pc, ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, is_mem, has_rd,
           is_ebreak, lsu_req_ready, lsu_rsp_valid
  );

  modport slave (
    input  pc, inst, ifu_req_valid, lsu_req_valid, rf_wen, halted, error, state,
           perf_cycles, perf_insts,
    output next_pc, ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, is_mem, has_rd,
           is_ebreak, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/npc_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and instruction register.
// Optional perf counters are built only when CTRL_PERF_EN is defined.
module npc_mc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255,
  parameter int          PERF_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  npc_mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT_I = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WAIT_D = 3'd5,
    S_WB     = 3'd6,
    S_STOP   = 3'd7
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        halted_q, halted_d;
  logic        error_q, error_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        wait_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= NOP;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    halted_d = halted_q;
    error_d  = error_q;
    tmo_d    = '0;
    wait_st  = 1'b0;
    case (state_q)
      S_FETCH: begin
        wait_st = 1'b1;
        if (bus.ifu_req_ready) state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        wait_st = 1'b1;
        if (bus.ifu_rsp_valid) begin
          inst_d  = bus.ifu_rsp_inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.is_ebreak) begin
          state_d  = S_STOP;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = bus.is_mem ? S_MEM : S_WB;
      S_MEM: begin
        wait_st = 1'b1;
        if (bus.lsu_req_ready) state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        wait_st = 1'b1;
        if (bus.lsu_rsp_valid) state_d = S_WB;
      end
      S_WB: begin
        pc_d    = bus.next_pc;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    // Progress in the same cycle always beats the timeout.
    if (wait_st && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_STOP;
        error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  // Requests and write enable are masked while reset is held.
  assign bus.ifu_req_valid = !rst && (state_q == S_FETCH);
  assign bus.lsu_req_valid = !rst && (state_q == S_MEM);
  assign bus.rf_wen        = !rst && (state_q == S_WB) && bus.has_rd;
  assign bus.pc            = pc_q;
  assign bus.inst          = inst_q;
  assign bus.halted        = halted_q;
  assign bus.error         = error_q;
  assign bus.state         = state_q;

`ifdef CTRL_PERF_EN
  logic [PERF_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_STOP) cyc_q <= cyc_q + 1'b1;
      if (state_q == S_WB)   ins_q <= ins_q + 1'b1;
    end
  end

  assign bus.perf_cycles = cyc_q;
  assign bus.perf_insts  = ins_q;
`else
  assign bus.perf_cycles = '0;
  assign bus.perf_insts  = '0;
`endif

endmodule

// File: tb/tb_npc_mc_ctrl.sv
// Random + directed bench for npc_mc_ctrl; an instruction-phase-list model is
// compared against the DUT on every negedge.
module tb_npc_mc_ctrl;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_mc_ctrl_if #(.PERF_W(32)) bus ();
  npc_mc_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic        np_rand_en = 1'b0;
  logic [31:0] np_rand    = '0;
  always_comb bus.next_pc = np_rand_en ? np_rand : bus.pc + 32'd4;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Model: each instruction is a list of phase codes still to run.
  int          plan[$];
  logic [31:0] m_pc, m_inst;
  bit          m_halt, m_err, known = 0;
  int          m_wait;
  logic [31:0] m_cyc, m_ins;

  function automatic void model_reset();
    plan   = {0, 1, 2, 3};
    m_pc   = RST_PC;
    m_inst = 32'h0000_0013;
    m_halt = 0; m_err = 0; m_wait = 0;
    m_cyc  = '0; m_ins = '0;
    known  = 1;
  endfunction

  function automatic void model_step();
    int cur;
    bit prog, waitp;
    cur = plan[0]; prog = 1; waitp = 0;
    m_cyc = m_cyc + 1;
    case (cur)
      0: begin waitp = 1; prog = bus.ifu_req_ready; end
      1: begin waitp = 1; prog = bus.ifu_rsp_valid; if (prog) m_inst = bus.ifu_rsp_inst; end
      2: if (bus.is_ebreak) m_halt = 1;
      4: begin waitp = 1; prog = bus.lsu_req_ready; end
      5: begin waitp = 1; prog = bus.lsu_rsp_valid; end
      default: ;
    endcase
    if (prog) begin
      m_wait = 0;
      void'(plan.pop_front());
      if (cur == 3) begin
        if (bus.is_mem) plan = {4, 5, 6};
        else            plan = {6};
      end
      if (cur == 6) begin
        m_pc  = bus.next_pc;
        m_ins = m_ins + 1;
        plan  = {0, 1, 2, 3};
      end
    end else if (waitp) begin
      m_wait++;
      if (m_wait == TMO) m_err = 1;
    end
  endfunction

  always @(negedge clk) begin
    int cur;
    if (known) begin
      cur = (m_halt || m_err) ? 7 : plan[0];
      chk("pc", bus.pc, m_pc);
      chk("inst", bus.inst, m_inst);
      chk("state", bus.state, cur);
      chk("ifu_req_valid", bus.ifu_req_valid, !rst && cur == 0);
      chk("lsu_req_valid", bus.lsu_req_valid, !rst && cur == 4);
      chk("rf_wen", bus.rf_wen, !rst && cur == 6 && bus.has_rd);
      chk("halted", bus.halted, m_halt);
      chk("error", bus.error, m_err);
`ifdef CTRL_PERF_EN
      chk("perf_cycles", bus.perf_cycles, m_cyc);
      chk("perf_insts", bus.perf_insts, m_ins);
`else
      chk("perf_cycles", bus.perf_cycles, 32'd0);
      chk("perf_insts", bus.perf_insts, 32'd0);
`endif
    end
    if (rst) model_reset();
    else if (known && !m_halt && !m_err) model_step();
  end

  task automatic zero_wait(bit mem, bit ebrk);
    bus.ifu_req_ready = 1; bus.ifu_rsp_valid = 1; bus.ifu_rsp_inst = 32'h0010_0093;
    bus.is_mem = mem; bus.has_rd = 1; bus.is_ebreak = ebrk;
    bus.lsu_req_ready = 1; bus.lsu_rsp_valid = 1; np_rand_en = 0;
  endtask

  // Holds reset across one checked cycle; the last posedge seen has rst=1.
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_inst", bus.inst, 32'h13);
    chk("rst_state", bus.state, 3'd0);
    chk("rst_valids", {bus.ifu_req_valid, bus.lsu_req_valid, bus.rf_wen}, 3'b000);
    chk("rst_flags", {bus.halted, bus.error}, 2'b00);
    chk("rst_perf", {bus.perf_cycles, bus.perf_insts}, 64'd0);
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic negs(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    zero_wait(0, 0);
    do_reset();

    // addi, zero-wait: rf_wen in cycle 5, pc advances after it
    negs(5);
    chk("addi_wen_c5", bus.rf_wen, 1'b1);
    chk("addi_pc_c5", bus.pc, 32'h8000_0000);
    negs(1);
    chk("addi_pc_next", bus.pc, 32'h8000_0004);
    chk("addi_wen_c6", bus.rf_wen, 1'b0);

    // fetch stalled 3 cycles
    do_reset();
    bus.ifu_req_ready = 0;
    negs(3);
    chk("stall_valid", bus.ifu_req_valid, 1'b1);
    chk("stall_state", bus.state, 3'd0);
    chk("stall_pc", bus.pc, RST_PC);
    @(posedge clk); #1 bus.ifu_req_ready = 1;

    // load, response arrives in cycle 8 -> WB in cycle 9
    do_reset();
    zero_wait(1, 0);
    bus.lsu_rsp_valid = 0;
    negs(7);
    chk("load_wait_d", bus.state, 3'd5);
    @(posedge clk); #1 bus.lsu_rsp_valid = 1;
    @(negedge clk);
    chk("load_wen_c8", bus.rf_wen, 1'b0);
    @(negedge clk);
    chk("load_wen_c9", bus.rf_wen, 1'b1);
    chk("load_wb", bus.state, 3'd6);
    @(negedge clk);
    chk("load_wen_c10", bus.rf_wen, 1'b0);
    chk("load_pc", bus.pc, 32'h8000_0004);

    // ebreak halts after DECODE
    do_reset();
    zero_wait(0, 1);
    negs(3);
    chk("ebrk_decode", bus.state, 3'd2);
    negs(1);
    chk("ebrk_state", bus.state, 3'd7);
    chk("ebrk_halted", bus.halted, 1'b1);
    negs(3);
    chk("ebrk_no_fetch", bus.ifu_req_valid, 1'b0);
    chk("ebrk_pc", bus.pc, RST_PC);
    bus.is_ebreak = 0;

    // instruction response never arrives
    do_reset();
    zero_wait(0, 0);
    bus.ifu_rsp_valid = 0;
    negs(9);
    chk("tmo_c9", {bus.state, bus.error}, {3'd1, 1'b0});
    negs(1);
    chk("tmo_c10", {bus.state, bus.error}, {3'd7, 1'b1});
    do_reset();
    @(negedge clk);
    chk("tmo_rst_pc", bus.pc, RST_PC);
    chk("tmo_rst_state", bus.state, 3'd0);

    // 10 zero-wait addi
    do_reset();
    zero_wait(0, 0);
    negs(51);
`ifdef CTRL_PERF_EN
    chk("perf_insts10", bus.perf_insts, 32'd10);
    chk("perf_cycles50", bus.perf_cycles, 32'd50);
`else
    chk("perf_insts_off", bus.perf_insts, 32'd0);
    chk("perf_cycles_off", bus.perf_cycles, 32'd0);
`endif

    // random traffic, random next_pc, sporadic resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst               = ($urandom_range(99) == 0);
      bus.ifu_req_ready = ($urandom_range(9) < 6);
      bus.ifu_rsp_valid = $urandom_range(1);
      bus.ifu_rsp_inst  = $urandom;
      bus.is_mem        = $urandom_range(1);
      bus.has_rd        = $urandom_range(1);
      bus.is_ebreak     = ($urandom_range(199) == 0);
      bus.lsu_req_ready = ($urandom_range(9) < 6);
      bus.lsu_rsp_valid = $urandom_range(1);
      np_rand_en        = ($urandom_range(3) == 0);
      np_rand           = $urandom;
    end
    @(posedge clk); #1 rst = 0;
    negs(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
